sort_job_ctrl: RTL and testbench

//   Job sequencer for the Sorter, running in the minor clock domain.
//   On start it streams ELEMENT_NUM words from unsorted memory (UM) into the Sorter as a contiguous UM_valid burst.
//   It then snoops Sorter writes into sorted memory (SM) and waits for the Sorter's done, with a watchdog.
//   It reports job_done, or job_err with a code.

---
 rtl/sort_job_ctrl_pkg.sv | 25 ++
 rtl/sort_job_ctrl_if.sv | 26 ++
 rtl/sort_job_ctrl_sm_cov_tracker.sv | 37 +++
 rtl/sort_job_ctrl.sv | 135 +++++++++++++
 tb/tb_sort_job_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_job_ctrl_pkg.sv
// rtl/sort_job_ctrl_pkg.sv - shared constants, FSM states and error codes for the sort job sequencer
package sort_job_ctrl_pkg;

    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_ELEMENT_NUM      = 128;
    localparam int DEF_LOG2_ELEMENT_NUM = 7;
    localparam int DEF_TIMEOUT_CYC      = 4096;
    localparam int DEF_TO_W             = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_WAIT,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_HOLE    = 2'b10,
        ERR_EARLY   = 2'b11
    } err_code_t;

endpackage

// File: rtl/sort_job_ctrl_if.sv
// rtl/sort_job_ctrl_if.sv - UM read port, Sorter feed stream and SM write snoop bundle
interface sort_job_ctrl_if
    import sort_job_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_W     = DEF_LOG2_ELEMENT_NUM
);
    logic                  um_rd_en;
    logic [ADDR_W-1:0]     um_rd_addr;
    logic [DATA_WIDTH-1:0] um_rd_data;
    logic                  UM_valid;
    logic [DATA_WIDTH-1:0] UM_data;
    logic                  SM_valid;
    logic [ADDR_W-1:0]     SM_addr;
    logic                  sorter_done;

    modport master (
        output um_rd_en, um_rd_addr, UM_valid, UM_data,
        input  um_rd_data, SM_valid, SM_addr, sorter_done
    );

    modport slave (
        input  um_rd_en, um_rd_addr, UM_valid, UM_data,
        output um_rd_data, SM_valid, SM_addr, sorter_done
    );
endinterface

// File: rtl/sort_job_ctrl_sm_cov_tracker.sv
// rtl/sort_job_ctrl_sm_cov_tracker.sv - SM address coverage bitmap and saturating write counter
module sort_job_ctrl_sm_cov_tracker
    import sort_job_ctrl_pkg::*;
#(
    parameter int ELEMENT_NUM      = DEF_ELEMENT_NUM,
    parameter int LOG2_ELEMENT_NUM = DEF_LOG2_ELEMENT_NUM
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        SM_valid,
    input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
    output logic                        all_set,
    output logic [LOG2_ELEMENT_NUM:0]   wr_cnt
);

    logic [ELEMENT_NUM-1:0] bitmap;

    // Duplicate addresses still bump the counter; only the bitmap deduplicates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
            wr_cnt <= '0;
        end else if (clr) begin
            bitmap <= '0;
            wr_cnt <= '0;
        end else if (en && SM_valid) begin
            bitmap[SM_addr] <= 1'b1;
            if (wr_cnt != '1)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

    assign all_set = &bitmap;

endmodule

// File: rtl/sort_job_ctrl.sv
// rtl/sort_job_ctrl.sv - sort job sequencer: UM burst into the Sorter, SM snoop, done/timeout supervision
module sort_job_ctrl
    import sort_job_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int ELEMENT_NUM      = DEF_ELEMENT_NUM,
    parameter int LOG2_ELEMENT_NUM = DEF_LOG2_ELEMENT_NUM,
    parameter int TIMEOUT_CYC      = DEF_TIMEOUT_CYC,
    parameter int TO_W             = DEF_TO_W
) (
    input  logic                      clk_mn,
    input  logic                      rst_n,
    input  logic                      start,
    sort_job_ctrl_if.master           bus,
    output logic                      busy,
    output logic                      job_done,
    output logic                      job_err,
    output logic [1:0]                err_code,
    output logic [LOG2_ELEMENT_NUM:0] wr_cnt
);

    localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_ADDR = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
    localparam logic [TO_W-1:0]             TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_t                      state, state_nx;
    err_code_t                   code_nx;
    logic [LOG2_ELEMENT_NUM-1:0] addr;
    logic [TO_W-1:0]             wd;
    logic [1:0]                  err_q;
    logic                        done_q, uv_q, jd_q;
    logic                        done_edge, accept, all_set;

    assign done_edge = bus.sorter_done & ~done_q;
    assign accept    = start && (state == ST_IDLE || state == ST_ERR);

    always_comb begin
        state_nx    = state;
        code_nx     = ERR_NONE;
        busy        = 1'b0;
        bus.um_rd_en = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (start)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                busy         = 1'b1;
                bus.um_rd_en = 1'b1;
                if (done_edge) begin
                    state_nx = ST_ERR;
                    code_nx  = ERR_EARLY;
                end else if (addr == LAST_ADDR) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (done_edge) begin
                    state_nx = ST_ERR;
                    code_nx  = ERR_EARLY;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                // A done edge outranks a watchdog expiry landing in the same cycle.
                if (done_edge) begin
                    if (all_set) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_ERR;
                        code_nx  = ERR_HOLE;
                    end
                end else if (wd == TO_LAST) begin
                    state_nx = ST_ERR;
                    code_nx  = ERR_TIMEOUT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mn or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr   <= '0;
            wd     <= '0;
            err_q  <= '0;
            done_q <= 1'b0;
            uv_q   <= 1'b0;
            jd_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= bus.sorter_done;
            // An aborted load must not present one more word after leaving LOAD.
            uv_q   <= (state == ST_LOAD) && (state_nx != ST_ERR);
            jd_q   <= (state == ST_WAIT) && (state_nx == ST_IDLE);
            if (accept) begin
                addr  <= '0;
                wd    <= '0;
                err_q <= '0;
            end else begin
                if (state == ST_LOAD)
                    addr <= addr + 1'b1;
                if (state == ST_WAIT)
                    wd <= wd + 1'b1;
                if (state_nx == ST_ERR && state != ST_ERR)
                    err_q <= code_nx;
            end
        end
    end

    sort_job_ctrl_sm_cov_tracker #(
        .ELEMENT_NUM      (ELEMENT_NUM),
        .LOG2_ELEMENT_NUM (LOG2_ELEMENT_NUM)
    ) u_cov (
        .clk      (clk_mn),
        .rst_n    (rst_n),
        .clr      (accept),
        .en       (busy),
        .SM_valid (bus.SM_valid),
        .SM_addr  (bus.SM_addr),
        .all_set  (all_set),
        .wr_cnt   (wr_cnt)
    );

    assign bus.um_rd_addr = addr;
    assign bus.UM_valid   = uv_q;
    assign bus.UM_data    = uv_q ? bus.um_rd_data : '0;
    assign job_done       = jd_q;
    assign job_err        = (state == ST_ERR);
    assign err_code       = err_q;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// tb/tb_sort_job_ctrl.sv - randomized bench for sort_job_ctrl against a cycle-indexed job model
module tb_sort_job_ctrl;
    import sort_job_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int N  = 128;
    localparam int L  = 7;
    localparam int TO = 64;
    localparam int TW = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, job_done, job_err;
    logic [1:0]   err_code;
    logic [L:0]   wr_cnt;

    sort_job_ctrl_if #(.DATA_WIDTH(DW), .ADDR_W(L)) bus ();

    sort_job_ctrl #(
        .DATA_WIDTH(DW), .ELEMENT_NUM(N), .LOG2_ELEMENT_NUM(L), .TIMEOUT_CYC(TO), .TO_W(TW)
    ) dut (
        .clk_mn   (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .job_done (job_done),
        .job_err  (job_err),
        .err_code (err_code),
        .wr_cnt   (wr_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [N];
    always @(posedge clk)
        if (bus.um_rd_en) bus.um_rd_data <= mem[bus.um_rd_addr];

    // Model: a job is a cycle index t since launch; t<N loads word t, t==N drains, t>N waits.
    logic       m_active, m_uv, m_jd, m_err, m_prev;
    logic [1:0] m_code;
    int         m_t, m_cnt, m_nseen, m_uaddr;
    bit         m_seen [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 0; m_uv <= 0; m_jd <= 0; m_err <= 0; m_prev <= 0; m_code <= 0;
            m_t <= 0; m_cnt <= 0; m_nseen <= 0; m_uaddr <= 0;
            for (int i = 0; i < N; i++) m_seen[i] <= 0;
        end else begin
            m_prev <= bus.sorter_done;
            m_jd   <= 0;
            m_uv   <= 0;
            if (m_active) begin
                m_t <= m_t + 1;
                if (bus.SM_valid) begin
                    m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (!m_seen[bus.SM_addr]) begin
                        m_seen[bus.SM_addr] <= 1;
                        m_nseen <= m_nseen + 1;
                    end
                end
                if (bus.sorter_done && !m_prev) begin
                    m_active <= 0;
                    if (m_t <= N) begin m_err <= 1; m_code <= 2'b11; end
                    else if (m_nseen == N) m_jd <= 1;
                    else begin m_err <= 1; m_code <= 2'b10; end
                end else begin
                    if (m_t > N && m_t - N == TO) begin
                        m_active <= 0; m_err <= 1; m_code <= 2'b01;
                    end
                    if (m_t < N) begin m_uv <= 1; m_uaddr <= m_t; end
                end
            end else if (start) begin
                m_active <= 1; m_t <= 0; m_cnt <= 0; m_nseen <= 0; m_err <= 0; m_code <= 0;
                for (int i = 0; i < N; i++) m_seen[i] <= 0;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    int uv_cnt, uv_runs, jd_cnt;
    logic last_uv, snap_en, snap_busy, snap_uv;
    logic [DW-1:0] last_data;

    task automatic run_job(input int hole, input int dup, input bit shuf, input int gap_pct,
                           input int done_min, input int early, input int extra_start,
                           input int rst_at, input int max_k, output int err_k);
        int q[$];
        int last_k, done_k, j, tmp;
        uv_cnt = 0; uv_runs = 0; jd_cnt = 0; last_uv = 0; last_data = '0; err_k = -1;
        snap_en = 0; snap_busy = 0; snap_uv = 0;
        for (int i = 0; i < N; i++) if (i != hole) q.push_back(i);
        if (dup >= 0) q.push_back(dup);
        if (shuf)
            for (int i = q.size() - 1; i > 0; i--) begin
                j = $urandom_range(i); tmp = q[i]; q[i] = q[j]; q[j] = tmp;
            end
        @(posedge clk); #2;
        start = 1;
        done_k = -1; last_k = 0;
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk); #2;
            start = (k == extra_start);
            bus.SM_valid = 0;
            bus.sorter_done = 0;
            if (bus.UM_valid) begin
                uv_cnt++;
                if (!last_uv) uv_runs++;
                last_data = bus.UM_data;
            end
            last_uv = bus.UM_valid;
            if (job_done) jd_cnt++;
            if (job_err && err_k < 0) begin
                err_k = k; snap_en = bus.um_rd_en; snap_busy = busy; snap_uv = bus.UM_valid;
            end
            if (k == rst_at) begin
                #1 rst_n = 0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_um_rd_en", bus.um_rd_en, 0);
                chk("rst_UM_valid", bus.UM_valid, 0);
                chk("rst_UM_data", bus.UM_data, 0);
                chk("rst_job_done", job_done, 0);
                chk("rst_job_err", job_err, 0);
                chk("rst_err_code", err_code, 0);
                chk("rst_wr_cnt", wr_cnt, 0);
                start = 0;
                return;
            end
            if (done_k >= 0) begin
                if (k >= done_k + 3) break;
            end else if (k == early) begin
                bus.sorter_done = 1; done_k = k;
            end else if (q.size() > 0 && ($urandom_range(99) >= gap_pct || k + q.size() >= 170)) begin
                bus.SM_valid = 1; bus.SM_addr = L'(q.pop_front()); last_k = k;
            end else if (q.size() == 0 && done_min >= 0 && k >= done_min && k > last_k) begin
                bus.sorter_done = 1; done_k = k;
            end
        end
        start = 0; bus.SM_valid = 0; bus.sorter_done = 0;
    endtask

    int ek, e, h, dm;

    initial begin
        bus.SM_valid = 0; bus.SM_addr = '0; bus.sorter_done = 0;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_um_rd_en", bus.um_rd_en, 0);
        chk("reset_um_rd_addr", bus.um_rd_addr, 0);
        chk("reset_UM_valid", bus.UM_valid, 0);
        chk("reset_job_done", job_done, 0);
        chk("reset_job_err", job_err, 0);
        chk("reset_err_code", err_code, 0);
        chk("reset_wr_cnt", wr_cnt, 0);
        @(posedge clk); #2 rst_n = 1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("busy", busy, m_active);
                    chk("um_rd_en", bus.um_rd_en, m_active && m_t < N);
                    if (m_active && m_t < N) chk("um_rd_addr", bus.um_rd_addr, m_t);
                    chk("UM_valid", bus.UM_valid, m_uv);
                    if (m_uv) chk("UM_data", bus.UM_data, mem[m_uaddr]);
                    chk("job_done", job_done, m_jd);
                    chk("job_err", job_err, m_err);
                    chk("err_code", err_code, m_code);
                    chk("wr_cnt", wr_cnt, m_cnt);
                end
            end
        join_none

        // T1: in-order writes, done in WAIT
        run_job(-1, -1, 0, 0, 131, -1, -1, -1, 200, ek);
        chk("t1_uv_cycles", uv_cnt, 128);
        chk("t1_uv_runs", uv_runs, 1);
        chk("t1_last_word", last_data, 127);
        chk("t1_job_done_pulses", jd_cnt, 1);
        chk("t1_wr_cnt", wr_cnt, 128);
        chk("t1_job_err", job_err, 0);

        // T2: no done, watchdog expires 64 cycles into WAIT
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        run_job(-1, -1, 1, 30, -1, -1, -1, -1, 200, ek);
        chk("t2_err_cycle", ek, 194);
        chk("t2_err_code", err_code, 2'b01);

        // T6: start from ERR, extra start mid-LOAD ignored
        run_job(-1, -1, 1, 20, 135, -1, 5, -1, 200, ek);
        chk("t6_uv_cycles", uv_cnt, 128);
        chk("t6_uv_runs", uv_runs, 1);
        chk("t6_job_done_pulses", jd_cnt, 1);
        chk("t6_job_err", job_err, 0);

        // T3: hole at 5, 6 written twice
        run_job(5, 6, 1, 20, 131, -1, -1, -1, 200, ek);
        chk("t3_err_code", err_code, 2'b10);
        chk("t3_wr_cnt", wr_cnt, 128);
        chk("t3_job_done_pulses", jd_cnt, 0);

        // T4: done on the 10th LOAD cycle, launched from ERR
        run_job(-1, -1, 1, 0, -1, 10, -1, -1, 30, ek);
        chk("t4_err_cycle", ek, 11);
        chk("t4_err_code", err_code, 2'b11);
        chk("t4_um_rd_en_after", snap_en, 0);
        chk("t4_busy_after", snap_busy, 0);
        chk("t4_UM_valid_after", snap_uv, 0);

        // T5: async reset mid-WAIT, then a clean job
        run_job(-1, -1, 1, 10, -1, -1, -1, 150, 200, ek);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        run_job(-1, -1, 0, 0, 131, -1, -1, -1, 200, ek);
        chk("t5_uv_cycles", uv_cnt, 128);
        chk("t5_job_done_pulses", jd_cnt, 1);
        chk("t5_wr_cnt", wr_cnt, 128);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            e  = ($urandom_range(3) == 0) ? int'($urandom_range(129, 1)) : -1;
            h  = ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1;
            dm = ($urandom_range(4) == 0) ? -1 : 131 + int'($urandom_range(20));
            run_job(h, -1, 1, $urandom_range(40), dm, e, $urandom_range(128, 1), -1, 200, ek);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
